// File: rtl/pulse_hold_tx.sv
// Sender side of a 4-phase req/ack crossing: turns single-cycle events into
// level handshakes and queues events that arrive while a handshake is running.
module pulse_hold_tx #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_CYC     = 255
) (
  input  logic             clk1,
  input  logic             rst_n1,
  input  logic             evt_in,
  input  logic             ack_in,
  input  logic             err_clr,
  output logic             req_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             ovf,
  output logic             tmo_err
);

  localparam int               TMO_W    = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REL
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   launch;
  logic                   tmo_hit;
  logic                   ovf_set;

  always_ff @(posedge clk1 or negedge rst_n1) begin
    if (!rst_n1) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // A launch starts a new handshake: from IDLE on any work, or straight from
  // REL once the receiver has released, so queued events skip the IDLE cycle.
  always_comb begin
    launch = 1'b0;
    if (state == IDLE) begin
      launch = evt_in || (pending != '0);
    end else if (state == REL) begin
      launch = !ack_s && (pending != '0);
    end
  end

  assign tmo_hit = (state == REQ) && !ack_s && (tmo_cnt == TMO_LAST);
  assign ovf_set = !launch && evt_in && (pending == PEND_MAX);

  always_ff @(posedge clk1 or negedge rst_n1) begin
    if (!rst_n1) begin
      state   <= IDLE;
      req_out <= 1'b0;
      busy    <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state   <= REQ;
            req_out <= 1'b1;
            busy    <= 1'b1;
            tmo_cnt <= '0;
          end
        end
        REQ: begin
          if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
          if (ack_s || tmo_hit) begin
            state   <= REL;
            req_out <= 1'b0;
          end
        end
        REL: begin
          if (!ack_s) begin
            if (launch) begin
              state   <= REQ;
              req_out <= 1'b1;
              tmo_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          req_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // A launch consumes one queued event unless a new one arrives alongside it.
  always_ff @(posedge clk1 or negedge rst_n1) begin
    if (!rst_n1) begin
      pending <= '0;
    end else if (launch) begin
      if ((pending != '0) && !evt_in) begin
        pending <= pending - 1'b1;
      end
    end else if (evt_in && (pending != PEND_MAX)) begin
      pending <= pending + 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n1) begin
    if (!rst_n1) begin
      ovf     <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      ovf     <= ovf_set || (ovf && !err_clr);
      tmo_err <= tmo_hit || (tmo_err && !err_clr);
    end
  end

endmodule

// File: tb/tb_pulse_hold_tx.sv
// Randomized and directed bench for pulse_hold_tx with an emulated receiver
// and a behavioural reference model of the handshake and event queue.
module tb_pulse_hold_tx;

  localparam int CNT_W    = 4;
  localparam int SYNC     = 2;
  localparam int TMO      = 8;
  localparam int PEND_MAX = (1 << CNT_W) - 1;

  logic             clk1 = 1'b0;
  logic             rst_n1;
  logic             evt_in;
  logic             ack_in;
  logic             err_clr;
  logic             req_out;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             ovf;
  logic             tmo_err;

  int n_vec  = 0;
  int n_fail = 0;

  bit m_req, m_busy, m_ovf, m_tmo;
  int m_pend, m_wait;
  bit ackq[$];

  int rx_mode;
  int rise_cnt, high_cnt, peak_pend;
  bit prev_req;

  pulse_hold_tx #(
    .CNT_W(CNT_W),
    .SYNC_STAGES(SYNC),
    .TMO_CYC(TMO)
  ) dut (
    .clk1(clk1),
    .rst_n1(rst_n1),
    .evt_in(evt_in),
    .ack_in(ack_in),
    .err_clr(err_clr),
    .req_out(req_out),
    .busy(busy),
    .pending(pending),
    .ovf(ovf),
    .tmo_err(tmo_err)
  );

  always #5 clk1 = ~clk1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req  = 0;
    m_busy = 0;
    m_ovf  = 0;
    m_tmo  = 0;
    m_pend = 0;
    m_wait = 0;
    ackq.delete();
    for (int i = 0; i < SYNC; i++) ackq.push_back(1'b0);
  endtask

  // Ack reaches the sender logic SYNC edges after it is sampled.
  task automatic model_edge();
    bit ack_s, launch, tmo_fire;
    ack_s = ackq[0];
    launch = 0;
    if (!m_busy) launch = evt_in || (m_pend > 0);
    else if (!m_req && !ack_s) launch = (m_pend > 0);
    tmo_fire = m_req && !ack_s && (m_wait == TMO - 1);

    if (!launch && evt_in && m_pend == PEND_MAX) m_ovf = 1;
    else if (err_clr) m_ovf = 0;
    if (tmo_fire) m_tmo = 1;
    else if (err_clr) m_tmo = 0;

    if (launch) begin
      if (m_pend > 0 && !evt_in) m_pend--;
    end else if (evt_in && m_pend < PEND_MAX) begin
      m_pend++;
    end

    if (launch) begin
      m_req  = 1;
      m_busy = 1;
      m_wait = 0;
    end else if (m_req) begin
      if (ack_s || tmo_fire) m_req = 0;
      else m_wait++;
    end else if (m_busy && !ack_s) begin
      m_busy = 0;
    end

    void'(ackq.pop_front());
    ackq.push_back(ack_in);
  endtask

  // One clock cycle: drive inputs at the falling edge, check after the next one.
  task automatic apply_stimulus(input bit evt, input bit clr);
    evt_in  = evt;
    err_clr = clr;
    case (rx_mode)
      0: begin
        if ($urandom_range(0, 1) == 0) ack_in = m_req;
        if (!m_busy && $urandom_range(0, 19) == 0) ack_in = ~ack_in;
      end
      1: ack_in = 1'b0;
      2: ack_in = 1'b1;
      default: ack_in = m_req;
    endcase
    model_edge();
    @(posedge clk1);
    @(negedge clk1);
    if (req_out === 1'b1 && !prev_req) rise_cnt++;
    prev_req = (req_out === 1'b1);
    if (req_out === 1'b1) high_cnt++;
    if (int'(pending) > peak_pend) peak_pend = int'(pending);
    check_output("req_out", req_out, m_req);
    check_output("busy",    busy,    m_busy);
    check_output("pending", pending, m_pend);
    check_output("ovf",     ovf,     m_ovf);
    check_output("tmo_err", tmo_err, m_tmo);
  endtask

  initial begin
    rst_n1  = 1'b0;
    evt_in  = 1'b0;
    ack_in  = 1'b0;
    err_clr = 1'b0;
    rx_mode = 3;
    prev_req = 0;
    model_reset();
    repeat (3) @(negedge clk1);
    check_output("rst_req",     req_out, 0);
    check_output("rst_busy",    busy,    0);
    check_output("rst_pending", pending, 0);
    check_output("rst_ovf",     ovf,     0);
    check_output("rst_tmo",     tmo_err, 0);
    rst_n1 = 1'b1;
    repeat (4) apply_stimulus(0, 0);

    $display("[TB] single event");
    rise_cnt = 0;
    apply_stimulus(1, 0);
    check_output("latency_req", req_out, 1);
    repeat (20) apply_stimulus(0, 0);
    check_output("single_rises", rise_cnt, 1);
    check_output("single_busy", busy, 0);
    check_output("single_pending", pending, 0);

    $display("[TB] burst of five");
    rise_cnt  = 0;
    peak_pend = 0;
    repeat (5) apply_stimulus(1, 0);
    repeat (60) apply_stimulus(0, 0);
    check_output("burst_peak", peak_pend, 4);
    check_output("burst_rises", rise_cnt, 5);
    check_output("burst_pending", pending, 0);

    $display("[TB] timeout");
    rx_mode  = 1;
    high_cnt = 0;
    apply_stimulus(1, 0);
    repeat (20) apply_stimulus(0, 0);
    check_output("tmo_high_cycles", high_cnt, TMO);
    check_output("tmo_flag", tmo_err, 1);
    check_output("tmo_idle", busy, 0);
    apply_stimulus(0, 1);
    check_output("tmo_cleared", tmo_err, 0);

    $display("[TB] overflow with receiver holding ack");
    rx_mode = 2;
    repeat (5) apply_stimulus(0, 0);
    check_output("spurious_busy", busy, 0);
    repeat (20) apply_stimulus(1, 0);
    check_output("ovf_pending", pending, 15);
    check_output("ovf_flag", ovf, 1);
    apply_stimulus(0, 1);
    check_output("ovf_cleared", ovf, 0);
    check_output("ovf_pending_kept", pending, 15);
    rx_mode  = 3;
    rise_cnt = 0;
    repeat (200) apply_stimulus(0, 0);
    check_output("drain_rises", rise_cnt, 15);
    check_output("drain_pending", pending, 0);

    $display("[TB] launch and event in the same cycle");
    rx_mode = 2;
    repeat (5) apply_stimulus(0, 0);
    repeat (4) apply_stimulus(1, 0);
    repeat (2) apply_stimulus(0, 0);
    check_output("simul_pre_pending", pending, 3);
    check_output("simul_pre_req", req_out, 0);
    rx_mode = 1;
    for (int i = 0; i < 10; i++) begin
      if (ackq[0] == 1'b0) begin
        apply_stimulus(1, 0);
        break;
      end
      apply_stimulus(0, 0);
    end
    check_output("simul_req", req_out, 1);
    check_output("simul_pending", pending, 3);

    $display("[TB] reset during a handshake");
    for (int i = 0; i < 300; i++) begin
      if (!m_busy && m_pend == 0) break;
      apply_stimulus(0, 0);
    end
    repeat (3) apply_stimulus(1, 0);
    check_output("mid_pending", pending, 2);
    check_output("mid_req", req_out, 1);
    #2 rst_n1 = 1'b0;
    #1;
    check_output("async_req",     req_out, 0);
    check_output("async_busy",    busy,    0);
    check_output("async_pending", pending, 0);
    check_output("async_ovf",     ovf,     0);
    check_output("async_tmo",     tmo_err, 0);
    model_reset();
    ack_in = 1'b0;
    evt_in = 1'b0;
    prev_req = 0;
    @(negedge clk1);
    rst_n1 = 1'b1;
    rx_mode = 3;
    repeat (3) apply_stimulus(0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 5))
          0, 1, 2: rx_mode = 0;
          3:       rx_mode = 3;
          4:       rx_mode = 1;
          default: rx_mode = 2;
        endcase
      end
      apply_stimulus($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
